spi_master_slave: RTL and testbench

Full-duplex, 8-bit SPI link: a `master` unit and a `slave` unit joined by internal `sclk`/`cs`/`mosi`/`miso` wires, all in one clock domain. It serves as the on-chip SPI endpoint pair and as the self-checking loopback for SPI mode bring-up. Each transaction swaps one byte. `data_tx` arrives in `data_rx_sl`, and `data_tx_sl` arrives in `data_rx`.

---
 rtl/spi_master_slave.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_spi_master_slave.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master_slave.sv
// Full-duplex 8-bit SPI master/slave loopback pair sharing one clock domain.
// Define SPI_LSB_FIRST_EN to shift LSB first on both mosi and miso; default is MSB first.

package spi_master_slave_pkg;
    function automatic logic out_bit(input logic [7:0] v);
`ifdef SPI_LSB_FIRST_EN
        return v[0];
`else
        return v[7];
`endif
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] v);
`ifdef SPI_LSB_FIRST_EN
        return {1'b0, v[7:1]};
`else
        return {v[6:0], 1'b0};
`endif
    endfunction

    function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, v[7:1]};
`else
        return {v[6:0], b};
`endif
    endfunction
endpackage

module master #(
    parameter int SCLK_HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] data_tx,
    input  logic       miso,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    output logic       done,
    output logic [7:0] data_rx
);
    import spi_master_slave_pkg::*;

    typedef enum logic [1:0] {IDLE, LOAD, XFER, FINISH} state_t;
    localparam int CW = $clog2(SCLK_HALF);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCLK_HALF - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    edge_q, edge_d;
    logic [7:0]    tx_q, tx_d, rx_q, rx_d, data_rx_q, data_rx_d;
    logic [1:0]    mode_q, mode_d;
    logic          start_prev_q;
    logic          sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d, done_q, done_d;
    logic          leading, sample, shift;

    // Leading edge leaves CPOL; CPHA picks whether it samples or shifts.
    assign leading = (sclk_q == mode_q[1]);
    assign sample  = leading ^ mode_q[0];
    assign shift   = !sample && !(!mode_q[0] && edge_q == 5'd15);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        mode_d    = mode_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        data_rx_d = data_rx_q;
        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = mode[1];
                if (start && !start_prev_q) begin
                    state_d = LOAD;
                    cs_d    = 1'b0;
                end
            end
            LOAD: begin
                tx_d    = data_tx;
                mode_d  = mode;
                cnt_d   = '0;
                edge_d  = '0;
                rx_d    = '0;
                state_d = XFER;
                if (!mode[0]) begin
                    mosi_d = out_bit(data_tx);
                    tx_d   = shift_out(data_tx);
                end
            end
            XFER: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (edge_q == 5'd16) begin
                        state_d   = FINISH;
                        cs_d      = 1'b1;
                        done_d    = 1'b1;
                        data_rx_d = rx_q;
                    end else begin
                        sclk_d = ~sclk_q;
                        edge_d = edge_q + 5'd1;
                        if (sample) begin
                            rx_d = shift_in(rx_q, miso);
                        end else if (shift) begin
                            mosi_d = out_bit(tx_q);
                            tx_d   = shift_out(tx_q);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            edge_q       <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            mode_q       <= '0;
            start_prev_q <= 1'b0;
            sclk_q       <= 1'b0;
            cs_q         <= 1'b1;
            mosi_q       <= 1'b0;
            done_q       <= 1'b0;
            data_rx_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            edge_q       <= edge_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            mode_q       <= mode_d;
            start_prev_q <= start;
            sclk_q       <= sclk_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            done_q       <= done_d;
            data_rx_q    <= data_rx_d;
        end
    end

    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;
    assign done    = done_q;
    assign data_rx = data_rx_q;
endmodule

module slave (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    input  logic [1:0] mode,
    input  logic [7:0] data_tx_sl,
    output logic       miso,
    output logic       done_sl,
    output logic [7:0] data_rx_sl
);
    import spi_master_slave_pkg::*;

    logic       sclk_dly_q, cs_dly_q;
    logic [7:0] tx_q, tx_d, rx_q, rx_d, data_rx_sl_q, data_rx_sl_d;
    logic [3:0] bit_q, bit_d;
    logic [1:0] mode_q, mode_d;
    logic       miso_q, miso_d, done_sl_q, done_sl_d;
    logic       leading;

    // sclk already holds the new level here, so a leading edge is one away from CPOL.
    assign leading = (sclk != mode_q[1]);

    always_comb begin
        tx_d         = tx_q;
        rx_d         = rx_q;
        bit_d        = bit_q;
        mode_d       = mode_q;
        miso_d       = miso_q;
        done_sl_d    = 1'b0;
        data_rx_sl_d = data_rx_sl_q;
        if (!cs && cs_dly_q) begin
            tx_d   = data_tx_sl;
            rx_d   = '0;
            bit_d  = '0;
            mode_d = mode;
            if (!mode[0]) begin
                miso_d = out_bit(data_tx_sl);
                tx_d   = shift_out(data_tx_sl);
            end
        end else if (cs && !cs_dly_q) begin
            data_rx_sl_d = rx_q;
            done_sl_d    = 1'b1;
            miso_d       = 1'b0;
        end else if (!cs && sclk != sclk_dly_q) begin
            if (leading ^ mode_q[0]) begin
                if (bit_q != 4'd8) begin
                    rx_d  = shift_in(rx_q, mosi);
                    bit_d = bit_q + 4'd1;
                end
            end else if (!(!mode_q[0] && bit_q == 4'd8)) begin
                miso_d = out_bit(tx_q);
                tx_d   = shift_out(tx_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_dly_q   <= 1'b0;
            cs_dly_q     <= 1'b1;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_q        <= '0;
            mode_q       <= '0;
            miso_q       <= 1'b0;
            done_sl_q    <= 1'b0;
            data_rx_sl_q <= '0;
        end else begin
            sclk_dly_q   <= sclk;
            cs_dly_q     <= cs;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            bit_q        <= bit_d;
            mode_q       <= mode_d;
            miso_q       <= miso_d;
            done_sl_q    <= done_sl_d;
            data_rx_sl_q <= data_rx_sl_d;
        end
    end

    assign miso       = miso_q;
    assign done_sl    = done_sl_q;
    assign data_rx_sl = data_rx_sl_q;
endmodule

module spi_master_slave #(
    parameter int SCLK_HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] data_tx,
    input  logic [7:0] data_tx_sl,
    output logic [7:0] data_rx,
    output logic [7:0] data_rx_sl,
    output logic       done,
    output logic       done_sl,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    output logic       miso
);
    master #(.SCLK_HALF(SCLK_HALF)) u_master (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .data_tx (data_tx),
        .miso    (miso),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .done    (done),
        .data_rx (data_rx)
    );

    slave u_slave (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .mode       (mode),
        .data_tx_sl (data_tx_sl),
        .miso       (miso),
        .done_sl    (done_sl),
        .data_rx_sl (data_rx_sl)
    );
endmodule

// File: tb/tb_spi_master_slave.sv
// Scoreboard bench for spi_master_slave: byte swap, done timing, CPOL/CPHA bus behaviour, reset abort.
module tb_spi_master_slave;
    localparam int H = 4;

    logic       clk, reset, start;
    logic [1:0] mode;
    logic [7:0] data_tx, data_tx_sl, data_rx, data_rx_sl;
    logic       done, done_sl, sclk, cs, mosi, miso;

    spi_master_slave #(.SCLK_HALF(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .data_tx    (data_tx),
        .data_tx_sl (data_tx_sl),
        .data_rx    (data_rx),
        .data_rx_sl (data_rx_sl),
        .done       (done),
        .done_sl    (done_sl),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] exp_sl_q[$];
    int         exp_t_q[$];
    int         exp_t_sl_q[$];
    int         n_checks = 0;
    int         n_pass = 0;

    logic [1:0] mon_mode = 2'b00;
    int         mosi_seen = 0;
    int         mosi_bad = 0;
    logic       mosi_p = 1'b0;
    logic       sclk_p = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: pops expectations whenever a done pulse appears
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'(done), 32'(1'b0));
            end else begin
                check("data_rx", 32'(data_rx), 32'(exp_q.pop_front()));
                check("done_time", cyc, exp_t_q.pop_front());
            end
        end
        if (!reset && done_sl) begin
            if (exp_sl_q.size() == 0) begin
                check("done_sl_unexpected", 32'(done_sl), 32'(1'b0));
            end else begin
                check("data_rx_sl", 32'(data_rx_sl), 32'(exp_sl_q.pop_front()));
                check("done_sl_time", cyc, exp_t_sl_q.pop_front());
            end
        end
    end

    // mosi may only change together with an sclk shift edge of the current mode
    always @(negedge clk) begin
        if (!reset && !cs && mosi != mosi_p && sclk != sclk_p) begin
            mosi_seen++;
            if ((sclk != mon_mode[1]) != mon_mode[0]) mosi_bad++;
        end
        mosi_p <= mosi;
        sclk_p <= sclk;
    end

    // driver: called on a negedge
    task automatic issue_xfer(input logic [1:0] m, input logic [7:0] tx, input logic [7:0] tx_sl,
                              input int width, input bit expect_done);
        mode       = m;
        data_tx    = tx;
        data_tx_sl = tx_sl;
        repeat (3) @(negedge clk);
        check("sclk_idle", 32'(sclk), 32'(m[1]));
        mon_mode  = m;
        mosi_seen = 0;
        mosi_bad  = 0;
        if (expect_done) begin
            exp_q.push_back(tx_sl);
            exp_sl_q.push_back(tx);
            exp_t_q.push_back(cyc + 2 + 17 * H);
            exp_t_sl_q.push_back(cyc + 3 + 17 * H);
        end
        start = 1'b1;
        repeat (width) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || exp_sl_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("xfer_timeout", 32'(n < 400), 32'd1);
        if (n >= 400) begin
            exp_q.delete();
            exp_sl_q.delete();
            exp_t_q.delete();
            exp_t_sl_q.delete();
        end
        check("mosi_edge_bad", mosi_bad, 0);
        check("mosi_edge_seen", 32'(mosi_seen > 0), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_values();
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_sl", 32'(done_sl), 32'd0);
        check("rst_data_rx", 32'(data_rx), 32'd0);
        check("rst_data_rx_sl", 32'(data_rx_sl), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 2'b00;
        data_tx    = 8'h00;
        data_tx_sl = 8'h00;
        @(negedge clk);
        check_reset_values();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // mode 2, one-clock start pulse
        issue_xfer(2'b10, 8'hBD, 8'hE7, 1, 1'b1);
        wait_done();

        // back-to-back in mode 2 with a ten-clock start
        issue_xfer(2'b10, 8'h6D, 8'h5D, 10, 1'b1);
        wait_done();
        issue_xfer(2'b10, 8'hF0, 8'hD4, 10, 1'b1);
        wait_done();
        issue_xfer(2'b10, 8'h6D, 8'hCE, 10, 1'b1);
        wait_done();

        // remaining modes
        issue_xfer(2'b00, 8'hA5, 8'h3C, 1, 1'b1);
        wait_done();
        issue_xfer(2'b01, 8'hA5, 8'h3C, 1, 1'b1);
        wait_done();
        issue_xfer(2'b11, 8'hA5, 8'h3C, 1, 1'b1);
        wait_done();

        // start held high: a single transaction only
        issue_xfer(2'b00, 8'h96, 8'h69, 200, 1'b1);
        wait_done();

        // reset during bit 4 aborts without a done pulse
        issue_xfer(2'b00, 8'hC3, 8'h3C, 1, 1'b0);
        repeat (29) @(negedge clk);
        check("cs_low_mid_xfer", 32'(cs), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (120) @(negedge clk);
        check("no_done_after_abort", 32'(exp_q.size()), 32'd0);
        issue_xfer(2'b00, 8'h5A, 8'h81, 1, 1'b1);
        wait_done();

        // mode change mid-transfer, then a transfer in the new mode
        issue_xfer(2'b01, 8'h3C, 8'hA5, 1, 1'b1);
        repeat (20) @(negedge clk);
        mode = 2'b11;
        wait_done();
        check("sclk_new_idle", 32'(sclk), 32'd1);
        issue_xfer(2'b11, 8'h81, 8'h7E, 1, 1'b1);
        wait_done();

        check("queues_empty", 32'(exp_q.size() + exp_sl_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
